// File: rtl/radix4_ntt_scheduler.sv
// ---------------------------------------------------------------------------
// radix4_ntt_scheduler
//
// Purpose:
//   Sequences a radix-4 DIF, in-place NTT/INTT over N = 4^LOG4N points. For
//   each of the LOG4N stages it issues N/4 butterfly groups. Each group is
//   four data addresses plus three twiddle exponents, offered on a
//   valid/ready handshake. Between stages it waits PIPE_LAT cycles so the
//   butterfly pipeline can finish writing back. It then pulses done.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, select       start request (sampled in IDLE), 0 = NTT / 1 = INTT
//   busy, done          busy from the cycle after start up to and including
//                       the done cycle; done is a one-cycle pulse
//   mode                select latched at start
//   stage               current stage index
//   bf_valid, bf_ready  group handshake
//   addr_0..addr_3      data addresses of the four butterfly legs
//   tw_exp_1..tw_exp_3  twiddle exponents of legs 1..3 (leg 0 is untwiddled)
//   state_dbg           current FSM state (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
//
// Handshake: a group transfers on a clock edge where bf_valid && bf_ready.
// Once bf_valid is raised it stays high, and the group fields plus stage and
// mode stay stable, until that transfer happens.
// ---------------------------------------------------------------------------
module radix4_ntt_scheduler #(
    parameter int width    = 32,
    parameter int LOG4N    = 3,
    parameter int ADDR_W   = 2 * LOG4N,
    parameter int PIPE_LAT = 4,
    localparam int STAGE_W = (LOG4N > 1) ? $clog2(LOG4N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               select,
    output logic               busy,
    output logic               done,
    output logic               mode,
    output logic [STAGE_W-1:0] stage,
    output logic               bf_valid,
    input  logic               bf_ready,
    output logic [ADDR_W-1:0]  addr_0,
    output logic [ADDR_W-1:0]  addr_1,
    output logic [ADDR_W-1:0]  addr_2,
    output logic [ADDR_W-1:0]  addr_3,
    output logic [ADDR_W-1:0]  tw_exp_1,
    output logic [ADDR_W-1:0]  tw_exp_2,
    output logic [ADDR_W-1:0]  tw_exp_3,
    output logic [1:0]         state_dbg
);

    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [ADDR_W-1:0]  LAST_B     = ADDR_W'((1 << (ADDR_W - 2)) - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG4N - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic [ADDR_W-1:0] a3;
        logic [ADDR_W-1:0] t1;
        logic [ADDR_W-1:0] t2;
        logic [ADDR_W-1:0] t3;
    } group_t;

    state_t            state;
    logic [ADDR_W-1:0] b_q;
    logic [CNT_W-1:0]  cnt_q;

    // Address and exponent set for group b of stage s. All sums wrap at
    // ADDR_W bits, which is exactly modulo N.
    function automatic group_t calc_group(input logic [STAGE_W-1:0] s,
                                          input logic [ADDR_W-1:0]  b,
                                          input logic               inv);
        group_t            g;
        int                sh;
        logic [ADDR_W-1:0] span;
        logic [ADDR_W-1:0] j;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] e1;
        logic [ADDR_W-1:0] e2;
        logic [ADDR_W-1:0] e3;
        sh   = 2 * (LOG4N - 1 - int'(s));            // log2(span)
        span = ADDR_W'(1) << sh;
        j    = b & (span - ADDR_W'(1));
        // blk*4*span: drop the j bits, then shift the block index up by 2 more
        base = ((b >> sh) << (sh + 2)) + j;
        g.a0 = base;
        g.a1 = base + span;
        g.a2 = base + (span << 1);
        g.a3 = base + span + (span << 1);
        e1   = j << (2 * s);                          // j * 4^s
        e2   = e1 << 1;
        e3   = e1 + e2;
        // Inverse transform uses the negated exponent; 0 - 0 stays 0.
        g.t1 = inv ? (ADDR_W'(0) - e1) : e1;
        g.t2 = inv ? (ADDR_W'(0) - e2) : e2;
        g.t3 = inv ? (ADDR_W'(0) - e3) : e3;
        return g;
    endfunction

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            b_q      <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mode     <= 1'b0;
            stage    <= '0;
            bf_valid <= 1'b0;
            {addr_0, addr_1, addr_2, addr_3, tw_exp_1, tw_exp_2, tw_exp_3} <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode     <= select;
                        stage    <= '0;
                        b_q      <= '0;
                        busy     <= 1'b1;
                        bf_valid <= 1'b1;
                        {addr_0, addr_1, addr_2, addr_3, tw_exp_1, tw_exp_2, tw_exp_3}
                            <= calc_group('0, '0, select);
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (bf_ready) begin
                        if (b_q != LAST_B) begin
                            b_q <= b_q + ADDR_W'(1);
                            {addr_0, addr_1, addr_2, addr_3, tw_exp_1, tw_exp_2, tw_exp_3}
                                <= calc_group(stage, b_q + ADDR_W'(1), mode);
                        end else if (PIPE_LAT > 0) begin
                            bf_valid <= 1'b0;
                            cnt_q    <= '0;
                            state    <= DRAIN;
                        end else if (stage == LAST_STAGE) begin
                            bf_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            // No drain: next stage's first group follows back to back.
                            stage <= stage + STAGE_W'(1);
                            b_q   <= '0;
                            {addr_0, addr_1, addr_2, addr_3, tw_exp_1, tw_exp_2, tw_exp_3}
                                <= calc_group(stage + STAGE_W'(1), '0, mode);
                        end
                    end
                end

                DRAIN: begin
                    // Fixed-length wait; bf_ready is irrelevant here.
                    if (cnt_q != DRAIN_LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (stage == LAST_STAGE) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        stage    <= stage + STAGE_W'(1);
                        b_q      <= '0;
                        bf_valid <= 1'b1;
                        {addr_0, addr_1, addr_2, addr_3, tw_exp_1, tw_exp_2, tw_exp_3}
                            <= calc_group(stage + STAGE_W'(1), '0, mode);
                        state    <= ISSUE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_ntt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_radix4_ntt_scheduler
//
// Bench for radix4_ntt_scheduler. dut_a uses the default build (PIPE_LAT=4).
// dut_b is a PIPE_LAT=0 build that shares the clock.
// All sampling and driving happens on the falling edge. In one falling-edge
// step the bench first samples the outputs, then sets the inputs that the
// next rising edge will see.
// ---------------------------------------------------------------------------
module tb_radix4_ntt_scheduler;

    localparam int ADDR_W = 6;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n = 0;           // falling-edge sample index
    int checks = 0;
    int errors = 0;

    // ---------------- dut_a (default build) ----------------
    logic              rst = 1'b1, start = 1'b0, select = 1'b0, bf_ready = 1'b1;
    logic              busy, done, mode, bf_valid;
    logic [1:0]        stage, state_dbg;
    logic [ADDR_W-1:0] addr_0, addr_1, addr_2, addr_3, tw_exp_1, tw_exp_2, tw_exp_3;

    radix4_ntt_scheduler #(.width(32), .LOG4N(3), .ADDR_W(ADDR_W), .PIPE_LAT(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .select(select),
        .busy(busy), .done(done), .mode(mode), .stage(stage),
        .bf_valid(bf_valid), .bf_ready(bf_ready),
        .addr_0(addr_0), .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3),
        .tw_exp_1(tw_exp_1), .tw_exp_2(tw_exp_2), .tw_exp_3(tw_exp_3),
        .state_dbg(state_dbg)
    );

    // ---------------- dut_b (PIPE_LAT = 0) ----------------
    logic              rst_b = 1'b1, start_b = 1'b0, select_b = 1'b0, bf_ready_b = 1'b1;
    logic              busy_b, done_b, mode_b, bf_valid_b;
    logic [1:0]        stage_b, state_dbg_b;
    logic [ADDR_W-1:0] addr_0_b, addr_1_b, addr_2_b, addr_3_b, tw_1_b, tw_2_b, tw_3_b;

    radix4_ntt_scheduler #(.width(32), .LOG4N(3), .ADDR_W(ADDR_W), .PIPE_LAT(0)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .select(select_b),
        .busy(busy_b), .done(done_b), .mode(mode_b), .stage(stage_b),
        .bf_valid(bf_valid_b), .bf_ready(bf_ready_b),
        .addr_0(addr_0_b), .addr_1(addr_1_b), .addr_2(addr_2_b), .addr_3(addr_3_b),
        .tw_exp_1(tw_1_b), .tw_exp_2(tw_2_b), .tw_exp_3(tw_3_b),
        .state_dbg(state_dbg_b)
    );

    // ---------------- scoreboard storage ----------------
    // Captured groups, indexed [select][stage][group], packed {a0..a3,t1..t3}.
    logic [7*ADDR_W-1:0] cap [2][3][16];
    int                  seen [3][64];

    typedef struct {
        int sel, s, b;
        int a0, a1, a2, a3;
        int t1, t2, t3;
    } vec_t;

    vec_t vecs[15];

    // ---------------- driver / check tasks ----------------
    task automatic step();
        @(negedge clk);
        n++;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One full transform on dut_a. The caller must be at a falling edge with
    // dut_a idle. An optional 5-cycle stall is applied while stage-0 group 2
    // is on offer.
    task automatic run_a(input logic sel, input bit do_stall, input int exp_done,
                         input string tag);
        int  t0;
        int  acc [3];
        int  stall_n;
        int  done_t;
        int  mode_bad;
        int  drop_bad;
        int  dup_bad;
        bit  prev_pend;
        logic rdy;
        t0 = n; stall_n = 0; done_t = -1; mode_bad = 0; drop_bad = 0; dup_bad = 0;
        prev_pend = 1'b0;
        for (int s = 0; s < 3; s++) begin
            acc[s] = 0;
            for (int a = 0; a < 64; a++) seen[s][a] = 0;
        end
        select = sel;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int k = 0; k < 200 && done_t < 0; k++) begin
            if (k == 0) begin
                chk({tag, " busy_first"}, int'(busy), 1);
                chk({tag, " valid_first"}, int'(bf_valid), 1);
                chk({tag, " stage_first"}, int'(stage), 0);
                chk({tag, " addr1_first"}, int'(addr_1), 16);
            end
            if (busy && (mode !== sel)) mode_bad++;
            if (prev_pend && !bf_valid) drop_bad++;
            if (done) done_t = n - t0;
            rdy = 1'b1;
            if (do_stall && bf_valid && stage == 2'd0 && acc[0] == 2 && stall_n < 5) begin
                rdy = 1'b0;
                stall_n++;
                chk("stall_addr0", int'(addr_0), 2);
                chk("stall_addr1", int'(addr_1), 18);
                chk("stall_addr2", int'(addr_2), 34);
                chk("stall_addr3", int'(addr_3), 50);
            end
            bf_ready = rdy;
            prev_pend = bf_valid && !rdy;
            if (bf_valid && rdy && stage < 2'd3) begin
                if (acc[stage] < 16)
                    cap[sel][stage][acc[stage]] =
                        {addr_0, addr_1, addr_2, addr_3, tw_exp_1, tw_exp_2, tw_exp_3};
                seen[stage][addr_0]++; seen[stage][addr_1]++;
                seen[stage][addr_2]++; seen[stage][addr_3]++;
                acc[stage]++;
            end
            step();
        end
        bf_ready = 1'b1;
        chk({tag, " done_cycle"}, done_t, exp_done);
        chk({tag, " busy_after_done"}, int'(busy), 0);
        chk({tag, " done_pulse_width"}, int'(done), 0);
        chk({tag, " mode_constant_bad"}, mode_bad, 0);
        chk({tag, " valid_dropped"}, drop_bad, 0);
        for (int s = 0; s < 3; s++) begin
            chk({tag, " groups_per_stage"}, acc[s], 16);
            for (int a = 0; a < 64; a++) if (seen[s][a] != 1) dup_bad++;
        end
        chk({tag, " addr_once_per_stage_bad"}, dup_bad, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t0, d1, d2, cnt_done, hit;
        logic [7*ADDR_W-1:0] g;

        //             sel s  b   a0  a1  a2  a3  t1  t2  t3
        vecs[0]  = '{0, 0, 0,   0, 16, 32, 48,  0,  0,  0};
        vecs[1]  = '{0, 0, 3,   3, 19, 35, 51,  3,  6,  9};
        vecs[2]  = '{0, 0, 10, 10, 26, 42, 58, 10, 20, 30};
        vecs[3]  = '{0, 0, 15, 15, 31, 47, 63, 15, 30, 45};
        vecs[4]  = '{0, 1, 0,   0,  4,  8, 12,  0,  0,  0};
        vecs[5]  = '{0, 1, 5,  17, 21, 25, 29,  4,  8, 12};
        vecs[6]  = '{0, 1, 15, 51, 55, 59, 63, 12, 24, 36};
        vecs[7]  = '{0, 2, 7,  28, 29, 30, 31,  0,  0,  0};
        vecs[8]  = '{0, 2, 15, 60, 61, 62, 63,  0,  0,  0};
        vecs[9]  = '{1, 0, 0,   0, 16, 32, 48,  0,  0,  0};
        vecs[10] = '{1, 0, 3,   3, 19, 35, 51, 61, 58, 55};
        vecs[11] = '{1, 0, 15, 15, 31, 47, 63, 49, 34, 19};
        vecs[12] = '{1, 1, 5,  17, 21, 25, 29, 60, 56, 52};
        vecs[13] = '{1, 1, 15, 51, 55, 59, 63, 52, 40, 28};
        vecs[14] = '{1, 2, 7,  28, 29, 30, 31,  0,  0,  0};

        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 3; s++)
                for (int b = 0; b < 16; b++) cap[i][s][b] = '1;

        // 1. Reset with start asserted, then idle outputs.
        rst = 1'b1; start = 1'b1; select = 1'b1;
        rst_b = 1'b1;
        repeat (3) step();
        rst = 1'b0; start = 1'b0; select = 1'b0;
        rst_b = 1'b0;
        step();
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst valid", int'(bf_valid), 0);
        chk("rst mode", int'(mode), 0);
        chk("rst stage", int'(stage), 0);
        chk("rst addr0", int'(addr_0), 0);
        chk("rst addr3", int'(addr_3), 0);
        chk("rst tw1", int'(tw_exp_1), 0);
        chk("rst state", int'(state_dbg), 0);
        step();
        chk("idle busy", int'(busy), 0);

        // 2./3. Full NTT then INTT, then the table comparison.
        run_a(1'b0, 1'b0, 61, "ntt");
        run_a(1'b1, 1'b0, 61, "intt");
        for (int i = 0; i < 15; i++) begin
            g = cap[vecs[i].sel][vecs[i].s][vecs[i].b];
            chk($sformatf("vec%0d addr0", i), int'(g[41:36]), vecs[i].a0);
            chk($sformatf("vec%0d addr1", i), int'(g[35:30]), vecs[i].a1);
            chk($sformatf("vec%0d addr2", i), int'(g[29:24]), vecs[i].a2);
            chk($sformatf("vec%0d addr3", i), int'(g[23:18]), vecs[i].a3);
            chk($sformatf("vec%0d tw1", i), int'(g[17:12]), vecs[i].t1);
            chk($sformatf("vec%0d tw2", i), int'(g[11:6]), vecs[i].t2);
            chk($sformatf("vec%0d tw3", i), int'(g[5:0]), vecs[i].t3);
        end

        // 4. Backpressure: 5 stall cycles on stage-0 group 2.
        run_a(1'b0, 1'b1, 66, "stall");

        // 5. Mid-operation reset during stage-1 issue.
        select = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        hit = 0;
        for (int k = 0; k < 100 && hit == 0; k++) begin
            if (bf_valid && stage == 2'd1) hit = 1;
            else step();
        end
        chk("midrst reached_stage1", hit, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst valid", int'(bf_valid), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst stage", int'(stage), 0);
        chk("midrst state", int'(state_dbg), 0);
        cnt_done = 0;
        for (int k = 0; k < 70; k++) begin
            if (done) cnt_done++;
            step();
        end
        chk("midrst no_done", cnt_done, 0);
        run_a(1'b0, 1'b0, 61, "restart");

        // 6. PIPE_LAT = 0 build with start held high.
        start_b = 1'b1;
        t0 = n; d1 = -1; d2 = -1; cnt_done = 0;
        step();
        while (n - t0 <= 100) begin
            if (done_b) begin
                cnt_done++;
                if (d1 < 0) d1 = n - t0;
                else if (d2 < 0) d2 = n - t0;
            end
            if (n - t0 == 17) begin
                chk("lat0 stage1_valid", int'(bf_valid_b), 1);
                chk("lat0 stage1_idx", int'(stage_b), 1);
                chk("lat0 stage1_addr1", int'(addr_1_b), 4);
            end
            if (n - t0 == 33) chk("lat0 stage2_idx", int'(stage_b), 2);
            if (n - t0 == 50) chk("lat0 idle_busy", int'(busy_b), 0);
            if (n - t0 == 51) begin
                chk("lat0 restart_valid", int'(bf_valid_b), 1);
                chk("lat0 restart_stage", int'(stage_b), 0);
                chk("lat0 restart_addr1", int'(addr_1_b), 16);
            end
            if (n - t0 == 60) start_b = 1'b0;
            step();
        end
        chk("lat0 first_done", d1, 49);
        chk("lat0 second_done", d2, 99);
        chk("lat0 done_count", cnt_done, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
